// File: rtl/cnn_win_sched.sv
`default_nettype none
// ============================================================================
// Module   : cnn_win_sched
// Purpose  : 3x3 window fetch scheduler for the CNN input path. Walks a
//            convolution window across an IMG_W x IMG_H image held in the
//            input RAM, issuing one read per cycle. Each read carries a tap
//            tag that is delayed by RD_LAT so the core receives a qualified
//            pixel stream. A read-after-write guard on wr_ptr lets fetching
//            overlap image loading. core_rdy paces windows to the core.
// Ports    : clk, rst_n (async, active-low)
//            start, abort            frame control pulses
//            wr_ptr [AW]             pixels already written to the RAM
//            core_rdy                core can take a new window
//            ram_rd, ram_addr [AW]   RAM read request
//            pix_vld, pix_tap[4],
//            pix_first, pix_last     tap tag aligned to RAM dout
//            busy, done              frame status
// Config   : CNN_WIN_STRIDE2_EN - stride 2 in both axes (default stride 1)
// Revision : 1.0 - initial release
// ============================================================================
module cnn_win_sched #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] wr_ptr,
  input  logic          core_rdy,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic          pix_vld,
  output logic [3:0]    pix_tap,
  output logic          pix_first,
  output logic          pix_last,
  output logic          busy,
  output logic          done
);

`ifdef CNN_WIN_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif

  // Final window position: largest multiple of STRIDE that still fits.
  localparam int LAST_C = ((IMG_W - 3) / STRIDE) * STRIDE;
  localparam int LAST_R = ((IMG_H - 3) / STRIDE) * STRIDE;

  localparam logic [AW-1:0] W1         = AW'(IMG_W);
  localparam logic [AW-1:0] W2         = AW'(2 * IMG_W);
  localparam logic [AW-1:0] RB_STEP    = AW'(STRIDE * IMG_W);
  localparam logic [AW-1:0] C_STEP     = AW'(STRIDE);
  localparam logic [AW-1:0] C_LAST     = AW'(LAST_C);
  localparam logic [AW-1:0] RB_LAST    = AW'(LAST_R * IMG_W);
  localparam logic [3:0]    DRAIN_LAST = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] rb;        // row base r*IMG_W
  logic [AW-1:0] c;         // column of window top-left
  logic [3:0]    t;         // tap index in FETCH, drain count in DRAIN
  logic [AW-1:0] base;
  logic [AW-1:0] anchor;
  logic [AW-1:0] row_off;
  logic [AW-1:0] col_off;
  logic          last_win;

  assign base     = rb + c;
  assign anchor   = base + W2 + AW'(2);   // bottom-right pixel of the window
  assign last_win = (rb == RB_LAST) && (c == C_LAST);

  // Tap -> (row, col) offset without a divider.
  always_comb begin
    row_off = '0;
    col_off = '0;
    case (t)
      4'd0: begin row_off = '0; col_off = AW'(0); end
      4'd1: begin row_off = '0; col_off = AW'(1); end
      4'd2: begin row_off = '0; col_off = AW'(2); end
      4'd3: begin row_off = W1; col_off = AW'(0); end
      4'd4: begin row_off = W1; col_off = AW'(1); end
      4'd5: begin row_off = W1; col_off = AW'(2); end
      4'd6: begin row_off = W2; col_off = AW'(0); end
      4'd7: begin row_off = W2; col_off = AW'(1); end
      4'd8: begin row_off = W2; col_off = AW'(2); end
      default: begin row_off = '0; col_off = '0; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and outputs
  always_comb begin
    state_nx = state;
    ram_rd   = 1'b0;
    ram_addr = '0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_WAIT;
      // core_rdy only matters here; once a window starts it runs to the end.
      S_WAIT:  if ((wr_ptr > anchor) && core_rdy) state_nx = S_FETCH;
      S_FETCH: begin
        ram_rd   = 1'b1;
        ram_addr = base + row_off + col_off;
        if (t == 4'd8) state_nx = S_DRAIN;
      end
      S_DRAIN: if (t == DRAIN_LAST) state_nx = last_win ? S_DONE : S_WAIT;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Window position and tap/drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb <= '0;
      c  <= '0;
      t  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rb <= '0;
          c  <= '0;
          t  <= '0;
        end
        S_FETCH: t <= (t == 4'd8) ? 4'd0 : t + 4'd1;
        S_DRAIN: begin
          if (t == DRAIN_LAST) begin
            t <= '0;
            if (!last_win) begin
              if (c != C_LAST) begin
                c <= c + C_STEP;
              end else begin
                c  <= '0;
                rb <= rb + RB_STEP;
              end
            end
          end else begin
            t <= t + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag pipeline {vld, tap[3:0], first, last}, RD_LAT deep to track RAM dout.
  logic [6:0] tag_in;
  logic [6:0] tag_q [RD_LAT];

  assign tag_in = (state == S_FETCH) ? {1'b1, t, (t == 4'd0), (t == 4'd8)} : 7'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else if (abort) begin
      // Reads already in flight are dropped so nothing leaks past an abort.
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign {pix_vld, pix_tap, pix_first, pix_last} = tag_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_cnn_win_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_win_sched
// Purpose  : Self-checking bench for cnn_win_sched. The expected read stream
//            is generated from window geometry (queues of addresses/taps),
//            and each read's tag is expected RD_LAT cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_win_sched;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int AW     = 10;
  localparam int RD_LAT = 1;
`ifdef CNN_WIN_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int NWX  = (IMG_W - 3) / S + 1;
  localparam int NWY  = (IMG_H - 3) / S + 1;
  localparam int NWIN = NWX * NWY;
  localparam int NPIX = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          core_rdy = 1'b0;
  logic [AW-1:0] wr_ptr = '0;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic          pix_vld;
  logic [3:0]    pix_tap;
  logic          pix_first;
  logic          pix_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  cnn_win_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .wr_ptr(wr_ptr),
    .core_rdy(core_rdy), .ram_rd(ram_rd), .ram_addr(ram_addr), .pix_vld(pix_vld),
    .pix_tap(pix_tap), .pix_first(pix_first), .pix_last(pix_last), .busy(busy),
    .done(done)
  );

  int errors = 0;
  int checks = 0;
  int cyc;

  // Reference model state
  int exp_addr[$];
  int exp_tap[$];
  int exp_anchor[$];
  int rd_idx;
  int pend_due[$];
  int pend_tap[$];
  int act_addr[$];
  int first_cnt;
  bit done_seen;
  int done_cyc;
  logic [AW-1:0] wr_prev;
  logic          rdy_prev;

  task automatic frame_model_init();
    exp_addr.delete();
    exp_tap.delete();
    exp_anchor.delete();
    pend_due.delete();
    pend_tap.delete();
    act_addr.delete();
    for (int wy = 0; wy < NWY; wy++) begin
      for (int wx = 0; wx < NWX; wx++) begin
        int b;
        b = wy * S * IMG_W + wx * S;
        for (int tp = 0; tp < 9; tp++) begin
          exp_addr.push_back(b + (tp / 3) * IMG_W + (tp % 3));
          exp_tap.push_back(tp);
          exp_anchor.push_back(b + 2 * IMG_W + 2);
        end
      end
    end
    rd_idx    = 0;
    first_cnt = 0;
    done_seen = 1'b0;
    done_cyc  = -1;
  endtask

  // Advance one cycle and check the read stream and tag stream against the model.
  task automatic step();
    int tp;
    wr_prev  = wr_ptr;
    rdy_prev = core_rdy;
    @(negedge clk);
    cyc++;
    if (ram_rd === 1'b1) begin
      checks++;
      if (rd_idx >= exp_addr.size()) begin
        errors++;
        $display("FAIL extra_read cyc=%0d got addr=%0d expected no read", cyc, ram_addr);
      end else begin
        if (ram_addr !== AW'(exp_addr[rd_idx])) begin
          errors++;
          $display("FAIL rd_addr cyc=%0d idx=%0d got=%0d exp=%0d", cyc, rd_idx, ram_addr, exp_addr[rd_idx]);
        end
        checks++;
        if (!(int'(wr_prev) > exp_anchor[rd_idx])) begin
          errors++;
          $display("FAIL raw_guard cyc=%0d got wr_ptr=%0d exp > %0d", cyc, wr_prev, exp_anchor[rd_idx]);
        end
        if (exp_tap[rd_idx] == 0) begin
          checks++;
          if (rdy_prev !== 1'b1) begin
            errors++;
            $display("FAIL core_rdy_gate cyc=%0d got core_rdy=%b exp 1", cyc, rdy_prev);
          end
        end
        pend_due.push_back(cyc + RD_LAT);
        pend_tap.push_back(exp_tap[rd_idx]);
        act_addr.push_back(int'(ram_addr));
        rd_idx++;
      end
    end
    checks++;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      tp = pend_tap[0];
      if (pix_vld !== 1'b1 || pix_tap !== tp[3:0] || pix_first !== (tp == 0) || pix_last !== (tp == 8)) begin
        errors++;
        $display("FAIL tag cyc=%0d got vld=%b tap=%0d first=%b last=%b exp vld=1 tap=%0d",
                 cyc, pix_vld, pix_tap, pix_first, pix_last, tp);
      end
      void'(pend_due.pop_front());
      void'(pend_tap.pop_front());
    end else if (pix_vld !== 1'b0 || pix_first !== 1'b0 || pix_last !== 1'b0) begin
      errors++;
      $display("FAIL tag_idle cyc=%0d got vld=%b first=%b last=%b exp 0", cyc, pix_vld, pix_first, pix_last);
    end
    if (pix_vld === 1'b1 && pix_first === 1'b1) first_cnt++;
    if (done === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  endtask

  // Called at a negedge: cycle 0 drives start, returns in cycle 1.
  task automatic frame_start();
    frame_model_init();
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
  endtask

  task automatic kill();
    abort = 1'b1;
    pend_due.delete();
    pend_tap.delete();
    step();
    abort = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ram_rd !== 1'b0 || ram_addr !== '0 || pix_vld !== 1'b0 || pix_tap !== 4'd0 ||
        pix_first !== 1'b0 || pix_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b addr=%0d vld=%b tap=%0d f=%b l=%b busy=%b done=%b exp all 0",
               ram_rd, ram_addr, pix_vld, pix_tap, pix_first, pix_last, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b rd=%b exp 0 0", busy, ram_rd);
    end
  endtask

  task automatic test_full_frame();
    int w0[9];
    w0 = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    wr_ptr   = AW'(NPIX);
    core_rdy = 1'b1;
    frame_start();
    checks++;
    if (busy !== 1'b1 || ram_rd !== 1'b0) begin
      errors++;
      $display("FAIL wait_cycle1 got busy=%b rd=%b exp 1 0", busy, ram_rd);
    end
    while (!done_seen && cyc < 20000) step();
    checks++;
    if (!done_seen || done_cyc != NWIN * (10 + RD_LAT) + 1) begin
      errors++;
      $display("FAIL done_cycle got seen=%0d cyc=%0d exp cyc=%0d", done_seen, done_cyc, NWIN * (10 + RD_LAT) + 1);
    end
    checks++;
    if (first_cnt != NWIN || rd_idx != NWIN * 9) begin
      errors++;
      $display("FAIL window_count got firsts=%0d reads=%0d exp %0d %0d", first_cnt, rd_idx, NWIN, NWIN * 9);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (act_addr.size() <= i || act_addr[i] != w0[i]) begin
        errors++;
        $display("FAIL win0_addr idx=%0d got=%0d exp=%0d", i, (act_addr.size() > i) ? act_addr[i] : -1, w0[i]);
      end
    end
    if (act_addr.size() == NWIN * 9) begin
`ifdef CNN_WIN_STRIDE2_EN
      checks++;
      if (act_addr[9] != 2 || act_addr[13 * 9] != 56) begin
        errors++;
        $display("FAIL stride2_base got w1=%0d w13=%0d exp 2 56", act_addr[9], act_addr[13 * 9]);
      end
`else
      checks++;
      if (act_addr[25 * 9] != 25 || act_addr[26 * 9] != 28 || act_addr[NWIN * 9 - 1] != 783) begin
        errors++;
        $display("FAIL row_wrap got w25=%0d w26=%0d last=%0d exp 25 28 783",
                 act_addr[25 * 9], act_addr[26 * 9], act_addr[NWIN * 9 - 1]);
      end
`endif
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cyc != done_cyc + 1) begin
      errors++;
      $display("FAIL busy_fall got busy=%b done=%b cyc=%0d exp 0 0 %0d", busy, done, cyc, done_cyc + 1);
    end
    checks++;
    if (pend_due.size() != 0) begin
      errors++;
      $display("FAIL tags_pending got %0d exp 0", pend_due.size());
    end
  endtask

  task automatic test_raw_guard();
    bit any_rd;
    wr_ptr   = AW'(58);
    core_rdy = 1'b1;
    frame_start();
    any_rd = 1'b0;
    repeat (20) begin
      step();
      if (ram_rd !== 1'b0) any_rd = 1'b1;
    end
    checks++;
    if (any_rd || busy !== 1'b1) begin
      errors++;
      $display("FAIL raw_hold got read=%0d busy=%b exp 0 1", any_rd, busy);
    end
    wr_ptr = AW'(59);
    step();
    checks++;
    if (ram_rd !== 1'b1 || ram_addr !== '0) begin
      errors++;
      $display("FAIL raw_release got rd=%b addr=%0d exp 1 0", ram_rd, ram_addr);
    end
    kill();
  endtask

  task automatic test_backpressure();
    bit any_rd;
    int w1[9];
    w1 = '{1, 2, 3, 29, 30, 31, 57, 58, 59};
    wr_ptr   = AW'(NPIX);
    core_rdy = 1'b1;
    frame_start();
    while (rd_idx < 9 && cyc < 40) step();
    core_rdy = 1'b0;
    any_rd   = 1'b0;
    repeat (30) begin
      step();
      if (ram_rd !== 1'b0) any_rd = 1'b1;
    end
    checks++;
    if (any_rd) begin
      errors++;
      $display("FAIL backpressure got read while core_rdy=0 exp none");
    end
    core_rdy = 1'b1;
    while (rd_idx < 18 && cyc < 100) step();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (act_addr.size() <= 9 + i || act_addr[9 + i] != w1[i]) begin
        errors++;
        $display("FAIL win1_addr idx=%0d got=%0d exp=%0d", i, (act_addr.size() > 9 + i) ? act_addr[9 + i] : -1, w1[i]);
      end
    end
    kill();
  endtask

  task automatic test_abort();
    bit saw_done;
    wr_ptr   = AW'(NPIX);
    core_rdy = 1'b1;
    frame_start();
    while (rd_idx < 5 && cyc < 30) step();
    checks++;
    if (rd_idx != 5) begin
      errors++;
      $display("FAIL abort_setup got reads=%0d exp 5", rd_idx);
    end
    abort = 1'b1;
    pend_due.delete();
    pend_tap.delete();
    step();
    abort = 1'b0;
    checks++;
    if (ram_rd !== 1'b0 || pix_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop got rd=%b vld=%b busy=%b exp 0 0 0", ram_rd, pix_vld, busy);
    end
    saw_done = 1'b0;
    repeat (15) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done got done/busy after abort exp none");
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start got busy=%b exp 0", busy);
    end
    frame_start();
    while (rd_idx < 1 && cyc < 20) step();
    checks++;
    if (act_addr.size() < 1 || act_addr[0] != 0 || cyc != 2) begin
      errors++;
      $display("FAIL restart got addr=%0d cyc=%0d exp 0 2", (act_addr.size() > 0) ? act_addr[0] : -1, cyc);
    end
    kill();
  endtask

  task automatic test_random();
    int nv;
    wr_ptr   = AW'($urandom_range(0, 40));
    core_rdy = 1'b1;
    frame_start();
    while (!done_seen && cyc < 30000) begin
      nv = int'(wr_ptr) + int'($urandom_range(0, 3));
      if (nv > NPIX) nv = NPIX;
      wr_ptr   = AW'(nv);
      core_rdy = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 199) == 0);
      step();
    end
    start = 1'b0;
    checks++;
    if (!done_seen || first_cnt != NWIN || rd_idx != NWIN * 9) begin
      errors++;
      $display("FAIL random_frame got done=%0d firsts=%0d reads=%0d exp 1 %0d %0d",
               done_seen, first_cnt, rd_idx, NWIN, NWIN * 9);
    end
    step();
    checks++;
    if (busy !== 1'b0 || pend_due.size() != 0) begin
      errors++;
      $display("FAIL random_end got busy=%b pending=%0d exp 0 0", busy, pend_due.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_raw_guard();
    test_backpressure();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
